// File: rtl/move_cmd_scheduler.sv
// Queues keyboard move pulses as coalesced direction commands and releases
// at most one per video frame to the movement block over valid/ready.
module move_cmd_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_RUN = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     move_up,
  input  logic                     move_down,
  input  logic                     move_left,
  input  logic                     move_right,
  input  logic                     frame_tick,
  input  logic                     cmd_ready,
  output logic                     cmd_valid,
  output logic [1:0]               cmd_dir,
  output logic [3:0]               cmd_run,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RUN_W = 4;
  localparam int unsigned DIR_W = 2;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [DIR_W-1:0]   dir_mem_q [DEPTH];
  logic [DIR_W-1:0]   dir_mem_d [DEPTH];
  logic [RUN_W-1:0]   run_mem_q [DEPTH];
  logic [RUN_W-1:0]   run_mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [DIR_W-1:0]   cmd_dir_q, cmd_dir_d;
  logic [RUN_W-1:0]   cmd_run_q, cmd_run_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;

  logic               press_c;
  logic [DIR_W-1:0]   press_dir_c;
  logic [PTR_W-1:0]   tail_c;
  logic               pop_c;
  logic               tail_pop_c;
  logic               coalesce_c;
  logic               push_c;
  logic               drop_c;

  // Press encode, queue decisions and FSM next state.
  always_comb begin
    state_d     = state_q;
    dir_mem_d   = dir_mem_q;
    run_mem_d   = run_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cmd_valid_d = cmd_valid_q;
    cmd_dir_d   = cmd_dir_q;
    cmd_run_d   = cmd_run_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;

    press_c     = move_up | move_down | move_left | move_right;
    press_dir_c = DIR_W'(0);
    if (move_up)         press_dir_c = DIR_W'(0);
    else if (move_down)  press_dir_c = DIR_W'(1);
    else if (move_left)  press_dir_c = DIR_W'(2);
    else if (move_right) press_dir_c = DIR_W'(3);

    tail_c     = wr_ptr_q - PTR_W'(1);
    pop_c      = (state_q == IDLE) && frame_tick && (count_q != CNT_W'(0));
    // With a single entry the tail is the head; a popped entry cannot grow.
    tail_pop_c = pop_c && (count_q == CNT_W'(1));
    coalesce_c = press_c && (count_q != CNT_W'(0)) &&
                 (dir_mem_q[tail_c] == press_dir_c) &&
                 (run_mem_q[tail_c] < RUN_W'(MAX_RUN)) && !tail_pop_c;
    push_c     = press_c && !coalesce_c && ((count_q != CNT_W'(DEPTH)) || pop_c);
    drop_c     = press_c && !coalesce_c && !push_c;

    if (coalesce_c) run_mem_d[tail_c] = run_mem_q[tail_c] + RUN_W'(1);
    if (push_c) begin
      dir_mem_d[wr_ptr_q] = press_dir_c;
      run_mem_d[wr_ptr_q] = RUN_W'(1);
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop_c) begin
          state_d     = HOLD;
          cmd_valid_d = 1'b1;
          cmd_dir_d   = dir_mem_q[rd_ptr_q];
          cmd_run_d   = run_mem_q[rd_ptr_q];
          rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end
      end
      HOLD: begin
        if (cmd_ready) begin
          state_d     = IDLE;
          cmd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dir_mem_q[i] <= DIR_W'(0);
        run_mem_q[i] <= RUN_W'(0);
      end
      wr_ptr_q    <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      count_q     <= CNT_W'(0);
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= DIR_W'(0);
      cmd_run_q   <= RUN_W'(0);
      overflow_q  <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      dir_mem_q   <= dir_mem_d;
      run_mem_q   <= run_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_dir_q   <= cmd_dir_d;
      cmd_run_q   <= cmd_run_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_dir    = cmd_dir_q;
  assign cmd_run    = cmd_run_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Directed bench for move_cmd_scheduler: coalescing, overflow, pacing, reset.
module tb_move_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_up, move_down, move_left, move_right;
  logic       frame_tick, cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic [3:0] cmd_run;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_count;

  int total = 0;
  int bad   = 0;

  move_cmd_scheduler #(.DEPTH(4), .MAX_RUN(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .frame_tick (frame_tick),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_dir    (cmd_dir),
    .cmd_run    (cmd_run),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int d);
    move_up    = (d == 0);
    move_down  = (d == 1);
    move_left  = (d == 2);
    move_right = (d == 3);
    step();
    move_up = 0; move_down = 0; move_left = 0; move_right = 0;
  endtask

  task automatic tick();
    frame_tick = 1;
    step();
    frame_tick = 0;
  endtask

  task automatic accept();
    cmd_ready = 1;
    step();
    cmd_ready = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    step(2);
    rst = 1;
    step();
  endtask

  task automatic test_reset();
    rst = 0;
    #3;
    total++;
    if ({cmd_valid, cmd_dir, cmd_run, fifo_count, overflow, drop_count} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state: got valid=%0b dir=%0d run=%0d cnt=%0d ovf=%0b drops=%0d want all 0",
               cmd_valid, cmd_dir, cmd_run, fifo_count, overflow, drop_count);
    end
    step(2);
    rst = 1;
    step();
  endtask

  task automatic test_coalesce();
    for (int i = 0; i < 3; i++) begin
      press(0);
      step(4);
    end
    total++;
    if (fifo_count !== 3'd1) begin bad++; $display("FAIL coalesce_count: got %0d want 1", fifo_count); end
    tick();
    total++;
    if ({cmd_valid, cmd_dir, cmd_run} !== {1'b1, 2'd0, 4'd3}) begin
      bad++;
      $display("FAIL coalesce_cmd: got valid=%0b dir=%0d run=%0d want 1/0/3", cmd_valid, cmd_dir, cmd_run);
    end
    accept();
    total++;
    if ({cmd_valid, fifo_count} !== {1'b0, 3'd0}) begin
      bad++;
      $display("FAIL coalesce_accept: got valid=%0b cnt=%0d want 0/0", cmd_valid, fifo_count);
    end
  endtask

  task automatic test_fill();
    logic [1:0] exp_dir [4];
    logic [3:0] exp_run [4];
    exp_dir[0] = 2; exp_run[0] = 1;
    exp_dir[1] = 3; exp_run[1] = 1;
    exp_dir[2] = 1; exp_run[2] = 15;
    exp_dir[3] = 1; exp_run[3] = 2;
    do_reset();
    press(2);
    press(3);
    for (int i = 0; i < 17; i++) press(1);
    total++;
    if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL fill_state: got cnt=%0d ovf=%0b want 4/0", fifo_count, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({cmd_valid, cmd_dir, cmd_run} !== {1'b1, exp_dir[i], exp_run[i]}) begin
        bad++;
        $display("FAIL fill_entry%0d: got valid=%0b dir=%0d run=%0d want 1/%0d/%0d",
                 i, cmd_valid, cmd_dir, cmd_run, exp_dir[i], exp_run[i]);
      end
      accept();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    press(0); press(1); press(0); press(1);
    press(2);
    total++;
    if ({fifo_count, overflow, drop_count} !== {3'd4, 1'b1, 8'd1}) begin
      bad++;
      $display("FAIL overflow_first: got cnt=%0d ovf=%0b drops=%0d want 4/1/1", fifo_count, overflow, drop_count);
    end
    for (int i = 0; i < 300; i++) press((i % 2 == 0) ? 0 : 2);
    total++;
    if ({fifo_count, drop_count} !== {3'd4, 8'd255}) begin
      bad++;
      $display("FAIL overflow_saturate: got cnt=%0d drops=%0d want 4/255", fifo_count, drop_count);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    move_up = 1; move_right = 1;
    step();
    move_up = 0; move_right = 0;
    total++;
    if ({fifo_count, drop_count} !== {3'd1, 8'd0}) begin
      bad++;
      $display("FAIL simul_count: got cnt=%0d drops=%0d want 1/0", fifo_count, drop_count);
    end
    tick();
    total++;
    if ({cmd_valid, cmd_dir, cmd_run} !== {1'b1, 2'd0, 4'd1}) begin
      bad++;
      $display("FAIL simul_cmd: got valid=%0b dir=%0d run=%0d want 1/0/1", cmd_valid, cmd_dir, cmd_run);
    end
    accept();
  endtask

  task automatic test_hold();
    do_reset();
    press(0); press(1);
    tick();
    for (int i = 0; i < 3; i++) begin
      step(2);
      tick();
      total++;
      if ({cmd_valid, cmd_dir, cmd_run, fifo_count} !== {1'b1, 2'd0, 4'd1, 3'd1}) begin
        bad++;
        $display("FAIL hold_stable%0d: got valid=%0b dir=%0d run=%0d cnt=%0d want 1/0/1/1",
                 i, cmd_valid, cmd_dir, cmd_run, fifo_count);
      end
    end
    accept();
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL hold_release: got valid=%0b want 0", cmd_valid); end
    step();
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL hold_no_tick: got valid=%0b want 0", cmd_valid); end
    tick();
    total++;
    if ({cmd_valid, cmd_dir, cmd_run, fifo_count} !== {1'b1, 2'd1, 4'd1, 3'd0}) begin
      bad++;
      $display("FAIL hold_next: got valid=%0b dir=%0d run=%0d cnt=%0d want 1/1/1/0",
               cmd_valid, cmd_dir, cmd_run, fifo_count);
    end
    accept();
  endtask

  task automatic test_tick_and_press();
    do_reset();
    press(0);
    move_up = 1; frame_tick = 1;
    step();
    move_up = 0; frame_tick = 0;
    total++;
    if ({cmd_valid, cmd_dir, cmd_run, fifo_count} !== {1'b1, 2'd0, 4'd1, 3'd1}) begin
      bad++;
      $display("FAIL same_cycle_pop: got valid=%0b dir=%0d run=%0d cnt=%0d want 1/0/1/1",
               cmd_valid, cmd_dir, cmd_run, fifo_count);
    end
    accept();
    tick();
    total++;
    if ({cmd_valid, cmd_dir, cmd_run, fifo_count} !== {1'b1, 2'd0, 4'd1, 3'd0}) begin
      bad++;
      $display("FAIL same_cycle_second: got valid=%0b dir=%0d run=%0d cnt=%0d want 1/0/1/0",
               cmd_valid, cmd_dir, cmd_run, fifo_count);
    end
    accept();
  endtask

  task automatic test_reset_hold();
    do_reset();
    press(0); press(1); press(0); press(1); press(2);
    tick();
    total++;
    if ({cmd_valid, overflow, fifo_count} !== {1'b1, 1'b1, 3'd3}) begin
      bad++;
      $display("FAIL rsthold_setup: got valid=%0b ovf=%0b cnt=%0d want 1/1/3", cmd_valid, overflow, fifo_count);
    end
    #2 rst = 0;
    #1;
    total++;
    if ({cmd_valid, fifo_count, overflow, drop_count} !== {1'b0, 3'd0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL rsthold_async: got valid=%0b cnt=%0d ovf=%0b drops=%0d want 0/0/0/0",
               cmd_valid, fifo_count, overflow, drop_count);
    end
    step(2);
    rst = 1;
    step();
    tick();
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rsthold_empty: got valid=%0b want 0", cmd_valid); end
  endtask

  initial begin
    rst = 1; move_up = 0; move_down = 0; move_left = 0; move_right = 0;
    frame_tick = 0; cmd_ready = 0;
    #1;
    test_reset();
    test_coalesce();
    test_fill();
    test_overflow();
    test_simultaneous();
    test_hold();
    test_tick_and_press();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
